i2c_master_arbiter: RTL

Round-robin arbiter that shares the single byte-level I2C master between two transaction requesters, e.g. the temperature-sensor sequencer and a second configuration client. It latches the winning requester's transaction descriptor, issues a one-cycle go to the master and routes the master's per-byte ready/read data back to the owner only. It holds ownership until the master reports completion, and aborts with an error if the master never starts.

---
 rtl/i2c_master_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one byte-level I2C master between two requesters.
// Latency: request seen in IDLE -> grant and m_go next cycle; rdy/rd_data are combinational.
// Backpressure: the losing requester holds req until served; ownership lasts until the master is idle again.

module i2c_master_arbiter #(
   parameter int START_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       rw0_i,
   input  logic       rw1_i,
   input  logic [1:0] nbyte0_i,
   input  logic [1:0] nbyte1_i,
   input  logic [7:0] ptr0_i,
   input  logic [7:0] ptr1_i,
   input  logic [6:0] dev0_i,
   input  logic [6:0] dev1_i,
   input  logic [7:0] dwr0_i,
   input  logic [7:0] dwr1_i,
   output logic       gnt0_o,
   output logic       gnt1_o,
   output logic       rdy0_o,
   output logic       rdy1_o,
   output logic       done0_o,
   output logic       done1_o,
   output logic       err0_o,
   output logic       err1_o,
   output logic [7:0] rd_data_o,
   output logic       m_go_o,
   output logic       m_rw_o,
   output logic [1:0] m_nbyte_o,
   output logic [7:0] m_ptr_o,
   output logic [6:0] m_dev_o,
   output logic [7:0] m_dwr_o,
   input  logic       m_ready_i,
   input  logic       m_done_i,
   input  logic [7:0] m_drd_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_ACTIVE,
      S_RELEASE
   } state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(START_TIMEOUT);

   state_t     state_q;
   logic       owner_q;
   logic       last_owner_q;
   logic [7:0] timer_q;
   logic       gnt0_q;
   logic       gnt1_q;
   logic       done0_q;
   logic       done1_q;
   logic       err0_q;
   logic       err1_q;
   logic       m_go_q;
   logic       m_rw_q;
   logic [1:0] m_nbyte_q;
   logic [7:0] m_ptr_q;
   logic [6:0] m_dev_q;

   logic       arb_d;
   logic       win_d;
   logic       active;

   // Arbitration: a sole requester wins; on a tie the requester that did not own last time wins.
   always_comb begin
      arb_d = m_done_i & (req0_i | req1_i);
      win_d = (req0_i & req1_i) ? ~last_owner_q : req1_i;
   end

   // Control FSM with registered grant, go, completion and descriptor outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         timer_q      <= 8'd0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         m_go_q       <= 1'b0;
         m_rw_q       <= 1'b0;
         m_nbyte_q    <= 2'd0;
         m_ptr_q      <= 8'd0;
         m_dev_q      <= 7'd0;
      end else begin
         // pulses default low; each is raised for exactly one cycle below
         m_go_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (arb_d) begin
                  owner_q   <= win_d;
                  m_rw_q    <= win_d ? rw1_i    : rw0_i;
                  m_nbyte_q <= win_d ? nbyte1_i : nbyte0_i;
                  m_ptr_q   <= win_d ? ptr1_i   : ptr0_i;
                  m_dev_q   <= win_d ? dev1_i   : dev0_i;
                  gnt0_q    <= ~win_d;
                  gnt1_q    <= win_d;
                  m_go_q    <= 1'b1;
                  state_q   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               timer_q <= 8'd0;
               state_q <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (!m_done_i) begin
                  state_q <= S_ACTIVE;
               end else if (timer_q == TIMEOUT_LIM) begin
                  // master never left idle: abort, the err pulse lands in RELEASE
                  gnt0_q  <= 1'b0;
                  gnt1_q  <= 1'b0;
                  err0_q  <= ~owner_q;
                  err1_q  <= owner_q;
                  state_q <= S_RELEASE;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            S_ACTIVE: begin
               if (m_done_i) begin
                  gnt0_q  <= 1'b0;
                  gnt1_q  <= 1'b0;
                  done0_q <= ~owner_q;
                  done1_q <= owner_q;
                  state_q <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               last_owner_q <= owner_q;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Byte-level routing is combinational so the master's strobes reach the owner with no delay.
   always_comb begin
      active    = (state_q == S_ACTIVE);
      rdy0_o    = m_ready_i & active & ~owner_q;
      rdy1_o    = m_ready_i & active & owner_q;
      rd_data_o = active ? m_drd_i : 8'h00;
      m_dwr_o   = gnt0_q ? dwr0_i : (gnt1_q ? dwr1_i : 8'h00);
   end

   assign gnt0_o    = gnt0_q;
   assign gnt1_o    = gnt1_q;
   assign done0_o   = done0_q;
   assign done1_o   = done1_q;
   assign err0_o    = err0_q;
   assign err1_o    = err1_q;
   assign m_go_o    = m_go_q;
   assign m_rw_o    = m_rw_q;
   assign m_nbyte_o = m_nbyte_q;
   assign m_ptr_o   = m_ptr_q;
   assign m_dev_o   = m_dev_q;

endmodule
